// File: rtl/cordic_rot_sequencer.sv
// Sequential CORDIC rotator. Each accepted (x, y) pair gets one initial stage and then
// cordic_steps-1 shift-and-add micro-rotations. The result is held until out_ready is seen.
module cordic_rot_sequencer #(
    parameter int unsigned data_width   = 16,
    parameter int unsigned cordic_steps = 16
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [data_width-1:0]   x_in,
    input  logic [data_width-1:0]   y_in,
    input  logic [1:0]              quad_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [data_width-1:0]   x_out,
    output logic [data_width-1:0]   y_out,
    output logic [cordic_steps-1:0] micro_rotation_out,
    output logic [1:0]              quad_out,
    output logic                    busy
);

    localparam int unsigned step_w = $clog2(cordic_steps);
    localparam logic [step_w-1:0] last_step = step_w'(cordic_steps - 1);

    typedef enum logic [1:0] {StIdle, StInit, StIter, StHold} state_t;

    state_t                        state_q, state_d;
    logic [step_w-1:0]             step_q, step_d;
    logic signed [data_width-1:0]  x_q, x_d, y_q, y_d;
    logic signed [data_width-1:0]  x_sh, y_sh;
    logic [cordic_steps-1:0]       mr_q, mr_d;
    logic [1:0]                    quad_q, quad_d;

    assign x_sh = x_q >>> step_q;
    assign y_sh = y_q >>> step_q;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        x_d     = x_q;
        y_d     = y_q;
        mr_d    = mr_q;
        quad_d  = quad_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d     = x_in;
                    y_d     = y_in;
                    quad_d  = quad_in;
                    state_d = StInit;
                end
            end
            StInit: begin
                x_d     = x_q + y_q;
                y_d     = y_q - x_q;
                mr_d    = cordic_steps'(1);
                step_d  = step_w'(1);
                state_d = StIter;
            end
            StIter: begin
                // Rotate positively while y is non-negative, driving y towards zero.
                if (!y_q[data_width-1]) begin
                    x_d          = x_q + y_sh;
                    y_d          = y_q - x_sh;
                    mr_d[step_q] = 1'b1;
                end else begin
                    x_d          = x_q - y_sh;
                    y_d          = y_q + x_sh;
                    mr_d[step_q] = 1'b0;
                end
                // Counter parks on the last stage so it never wraps within a job.
                if (step_q == last_step) begin
                    state_d = StHold;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= StIdle;
            step_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mr_q    <= '0;
            quad_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mr_q    <= mr_d;
            quad_q  <= quad_d;
        end
    end

    assign in_ready           = (state_q == StIdle);
    assign out_valid          = (state_q == StHold);
    assign busy               = (state_q != StIdle);
    assign x_out              = x_q;
    assign y_out              = y_q;
    assign micro_rotation_out = mr_q;
    assign quad_out           = quad_q;

endmodule

// File: tb/tb_cordic_rot_sequencer.sv
// Bench for cordic_rot_sequencer: directed datapath/latency/reset cases, then a random stream,
// all checked against an integer-arithmetic model of the rotation and job timing.
module tb_cordic_rot_sequencer;

    localparam int DW = 16;
    localparam int NS = 16;

    typedef struct packed {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [NS-1:0] mr;
        logic [1:0]    q;
    } res_t;

    logic          clk = 1'b0;
    logic          nreset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] x_in = '0;
    logic [DW-1:0] y_in = '0;
    logic [1:0]    quad_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] x_out;
    logic [DW-1:0] y_out;
    logic [NS-1:0] micro_rotation_out;
    logic [1:0]    quad_out;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    cordic_rot_sequencer #(
        .data_width  (DW),
        .cordic_steps(NS)
    ) dut (
        .clk               (clk),
        .nreset            (nreset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .x_in              (x_in),
        .y_in              (y_in),
        .quad_in           (quad_in),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .x_out             (x_out),
        .y_out             (y_out),
        .micro_rotation_out(micro_rotation_out),
        .quad_out          (quad_out),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Two's-complement wrap of an int into DW bits, returned sign-extended.
    function automatic int wrap(input int v);
        int r;
        r = v & ((1 << DW) - 1);
        if (r >= (1 << (DW - 1))) r = r - (1 << DW);
        return r;
    endfunction

    function automatic res_t model(input logic [DW-1:0] xi, input logic [DW-1:0] yi,
                                   input logic [1:0] qi);
        res_t r;
        int x, y, nx, ny;
        x = int'($signed(xi));
        y = int'($signed(yi));
        nx = wrap(x + y);
        ny = wrap(y - x);
        x = nx;
        y = ny;
        r.mr = NS'(1);
        for (int i = 1; i < NS; i++) begin
            if (y >= 0) begin
                nx = wrap(x + (y >>> i));
                ny = wrap(y - (x >>> i));
                r.mr[i] = 1'b1;
            end else begin
                nx = wrap(x - (y >>> i));
                ny = wrap(y + (x >>> i));
                r.mr[i] = 1'b0;
            end
            x = nx;
            y = ny;
        end
        r.x = x[DW-1:0];
        r.y = y[DW-1:0];
        r.q = qi;
        return r;
    endfunction

    // Job-level model: busy for NS edges of compute, then holding until out_ready.
    logic m_busy = 1'b0;
    int   m_cnt = 0;
    res_t e_res = '0;

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            e_res  <= '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                e_res  <= model(x_in, y_in, quad_in);
            end
        end else if (m_cnt < NS) begin
            m_cnt <= m_cnt + 1;
        end else if (out_ready) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("in_ready", 64'(in_ready), 64'(!m_busy));
        check("busy", 64'(busy), 64'(m_busy));
        check("out_valid", 64'(out_valid), 64'(m_busy && m_cnt == NS));
        if (!m_busy || m_cnt == NS) begin
            check("x_out", 64'(x_out), 64'(e_res.x));
            check("y_out", 64'(y_out), 64'(e_res.y));
            check("micro_rotation_out", 64'(micro_rotation_out), 64'(e_res.mr));
            check("quad_out", 64'(quad_out), 64'(e_res.q));
        end
    end

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!in_ready && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_ready: in_ready 0 expected 1 within %0d cycles", budget);
        end
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!out_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_valid: out_valid 0 expected 1 within %0d cycles", budget);
        end
    endtask

    // Returns just after the accept edge (E0 + 2).
    task automatic start_job(input logic [DW-1:0] x, input logic [DW-1:0] y,
                             input logic [1:0] q);
        wait_ready(40);
        in_valid = 1'b1;
        x_in     = x;
        y_in     = y;
        quad_in  = q;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"}, 64'(x_out), 64'h0);
        check({tag, "_y"}, 64'(y_out), 64'h0);
        check({tag, "_mr"}, 64'(micro_rotation_out), 64'h0);
        check({tag, "_quad"}, 64'(quad_out), 64'h0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'h1);
        check({tag, "_busy"}, 64'(busy), 64'h0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'h0);
    endtask

    res_t ref1000;

    initial begin
        #1 nreset = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #2 nreset = 1'b1;

        // Datapath pins, latency, ignored in_valid, backpressure.
        out_ready = 1'b0;
        start_job(16'd1000, 16'd0, 2'd2);
        check("accept_busy", 64'(busy), 64'h1);
        check("accept_in_ready", 64'(in_ready), 64'h0);
        @(posedge clk);
        #2;
        check("init_x", 64'(x_out), 64'd1000);
        check("init_y", 64'(y_out), 64'hFC18);
        check("init_mr", 64'(micro_rotation_out), 64'h0001);
        in_valid = 1'b1;
        x_in     = 16'h1234;
        y_in     = 16'h4321;
        quad_in  = 2'd1;
        @(posedge clk);
        #2;
        check("step1_x", 64'(x_out), 64'd1500);
        check("step1_y", 64'(y_out), 64'hFE0C);
        check("step1_mr", 64'(micro_rotation_out), 64'h0001);
        in_valid = 1'b0;
        repeat (13) @(posedge clk);
        #2;
        check("e15_out_valid", 64'(out_valid), 64'h0);
        @(posedge clk);
        #2;
        check("e16_out_valid", 64'(out_valid), 64'h1);
        check("e16_quad", 64'(quad_out), 64'd2);
        repeat (5) begin
            @(posedge clk);
            #2;
            check("hold_out_valid", 64'(out_valid), 64'h1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        check("release_in_ready", 64'(in_ready), 64'h1);
        check("release_out_valid", 64'(out_valid), 64'h0);

        // Wrapping initial stage.
        start_job(16'h7FFF, 16'h7FFF, 2'd3);
        @(posedge clk);
        #2;
        check("wrap_x", 64'(x_out), 64'hFFFE);
        check("wrap_y", 64'(y_out), 64'h0000);
        wait_valid(40);
        @(posedge clk);
        #2;

        // Reset during ITER step 7, then rerun the reference job.
        start_job(16'd1000, 16'd0, 2'd2);
        repeat (7) @(posedge clk);
        #2 nreset = 1'b0;
        #1 check_reset_outputs("midjob");
        @(posedge clk);
        #2 nreset = 1'b1;
        start_job(16'd1000, 16'd0, 2'd2);
        wait_valid(40);
        ref1000 = model(16'd1000, 16'd0, 2'd2);
        check("rerun_x", 64'(x_out), 64'(ref1000.x));
        check("rerun_y", 64'(y_out), 64'(ref1000.y));
        check("rerun_mr", 64'(micro_rotation_out), 64'(ref1000.mr));
        check("rerun_quad", 64'(quad_out), 64'd2);
        @(posedge clk);
        #2;

        // Random stream with occasional asynchronous resets.
        repeat (3000) begin
            @(posedge clk);
            #2;
            in_valid  = ($urandom_range(0, 3) == 0);
            x_in      = DW'($urandom);
            y_in      = DW'($urandom);
            quad_in   = 2'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            nreset    = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk);
        #2;
        nreset    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (NS + 4) @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cordic_rot_sequencer.md
CORDIC_ROT_SEQUENCER -- requirements
Module: cordic_rot_sequencer

Interface
REQ-001 SHALL have parameter data_width, default 16, meaning the two's-complement width of the x/y datapath.
REQ-002 SHALL have parameter cordic_steps, default 16, meaning the total CORDIC stages (the initial stage plus cordic_steps-1 micro-rotations), legal range >= 2.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  input  1  sole clock; all state updates on the rising edge.
- nreset  input  1  asynchronous, active-low reset.
- in_valid  input  1  request to start a job.
- in_ready  output  1  block can accept a job.
- x_in  input  data_width  signed start x.
- y_in  input  data_width  signed start y.
- quad_in  input  2  quadrant tag, passed through.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- x_out  output  data_width  signed result x.
- y_out  output  data_width  signed result y.
- micro_rotation_out  output  cordic_steps  direction word, bit i set to 1 = positive rotation at stage i.
- quad_out  output  2  quadrant tag of the current job.
- busy  output  1  a job is in INIT, ITER or HOLD.
REQ-004 SHALL use one clock, clk; reset nreset SHALL be asynchronous and active-low.

Function
REQ-005 SHALL implement the FSM states IDLE, INIT, ITER and HOLD, with all outputs registered or decoded from state.
REQ-006 SHALL drive in_ready=1 only in IDLE; a job is accepted on a rising edge where in_valid=1 and in_ready=1.
- On accept: latch x_in, y_in and quad_in, then go to INIT.
REQ-007 SHALL ignore in_valid outside IDLE: no queuing, no effect on the job in flight.
REQ-008 INIT SHALL last exactly one cycle, then go to ITER. On that cycle:
- x <= x+y, y <= y-x (both computed from the old values).
- micro_rotation <= 1 (only bit 0 set).
- step <= 1.
REQ-009 In ITER at step i (1..cordic_steps-1), the block SHALL compute d = NOT sign(y).
- If d=1: x <= x + (y>>>i), y <= y - (x>>>i), micro_rotation[i] <= 1.
- If d=0: x <= x - (y>>>i), y <= y + (x>>>i), micro_rotation[i] <= 0.
- All operands are the old register values.
REQ-010 `>>>` SHALL be an arithmetic (sign-extending) right shift; all add/subtract SHALL wrap modulo 2^data_width, with no saturation and no width growth.
REQ-011 The step counter SHALL be $clog2(cordic_steps) bits wide and increment once per ITER cycle.
- After the stage with i = cordic_steps-1: go to HOLD; the counter SHALL never wrap inside a job.
REQ-012 HOLD SHALL assert out_valid=1 with x_out, y_out, micro_rotation_out and quad_out held stable until a rising edge with out_ready=1, then go to IDLE.
REQ-013 Latency: out_valid SHALL first be 1 after the cordic_steps-th rising edge following the accept edge.
- Next accept is possible no earlier than the edge after the out_ready handshake (at least one idle cycle between jobs).
REQ-014 If out_ready is already 1 when HOLD is entered, out_valid SHALL be high for exactly one cycle.
REQ-015 busy SHALL be 1 in INIT, ITER and HOLD, and 0 in IDLE.
REQ-016 x_out, y_out, micro_rotation_out and quad_out SHALL be the internal registers directly; they keep their last values in IDLE until the next accept overwrites them.

Reset
REQ-017 While nreset=0, the block SHALL force:
- state=IDLE, step=0.
- x_out, y_out, micro_rotation_out and quad_out = 0.
- out_valid=0, busy=0.
- in_ready=1.
REQ-018 Reset asserted in any state (including mid-ITER or HOLD) SHALL abort the job, with no partial result presented; the first edge after release behaves as IDLE.

Verification (data_width=16, cordic_steps=16)
REQ-019 Reset: assert nreset=0 mid-sim -> all outputs 0 immediately (async), in_ready=1, busy=0.
REQ-020 Datapath, x_in=1000, y_in=0, quad_in=2:
- After INIT: x=1000, y=-1000, micro_rotation=0x0001.
- After step 1: x=1500, y=-500, bit1=0.
- quad_out=2 at out_valid.
REQ-021 Latency: accept at edge E0 -> out_valid=1 after edge E16.
- in_ready=0 and busy=1 from E0 to the handshake.
- in_valid pulses during the job are ignored.
REQ-022 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> outputs unchanged and out_valid=1 throughout; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-023 Mid-job reset: drop nreset during ITER step 7 -> IDLE, outputs 0; a new job x_in=1000, y_in=0 then completes with results identical to REQ-020.
REQ-024 Wrap: x_in=0x7FFF, y_in=0x7FFF -> after INIT x=0xFFFE (wrapped), y=0x0000; no saturation.
